// File: rtl/act_mem_pkg.sv
// Shared definitions for the activation memory read/write controllers:
// layer mode codes, default geometry and the write controller state encoding.
package act_mem_pkg;

    localparam int AM_ADDR_W = 13;
    localparam int AM_DATA_W = 16;
    localparam int AM_ROW_W  = 16;
    localparam int AM_ROWS   = 14;
    localparam int AM_FC_LEN = 512;

    localparam logic [1:0] CONV = 2'b01;
    localparam logic [1:0] FC   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_CONV = 2'd1,
        ST_WR_FC   = 2'd2,
        ST_DONE    = 2'd3
    } wr_state_t;

    // Conv rows rotate through the three banks 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_bank(input logic [1:0] sel);
        return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage

// File: rtl/act_wr_addr_gen.sv
// Write address generator: column/row/bank counters for conv layers and a
// linear counter for FC layers; addresses are built from running offsets.
module act_wr_addr_gen
    import act_mem_pkg::*;
#(
    parameter int ROW_W  = AM_ROW_W,
    parameter int ROWS   = AM_ROWS,
    parameter int FC_LEN = AM_FC_LEN,
    parameter int ADDR_W = AM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_conv_beat,
    input  logic              i_fc_beat,
    output logic [ADDR_W-1:0] o_conv_addr,
    output logic [1:0]        o_bank_sel,
    output logic              o_conv_last,
    output logic [ADDR_W-1:0] o_fc_addr,
    output logic              o_fc_last
);

    localparam int COL_W  = (ROW_W  > 1) ? $clog2(ROW_W)  : 1;
    localparam int ROW_CW = (ROWS   > 1) ? $clog2(ROWS)   : 1;
    localparam int FC_W   = (FC_LEN > 1) ? $clog2(FC_LEN) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_W - 1);
    localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(ROWS - 1);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(FC_LEN - 1);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_line_off;
    logic [COL_W-1:0]  r_col;
    logic [ROW_CW-1:0] r_row;
    logic [1:0]        r_bank_sel;
    logic [FC_W-1:0]   r_fc_cnt;

    // NOTE: all state here uses non-blocking assignments so every counter
    // sees the pre-edge value of its neighbours within the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_line_off <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_bank_sel <= '0;
            r_fc_cnt   <= '0;
        end else if (i_load) begin
            r_base     <= i_base_addr;
            r_line_off <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_bank_sel <= '0;
            r_fc_cnt   <= '0;
        end else begin
            if (i_conv_beat) begin
                if (r_col == COL_LAST) begin
                    r_col      <= '0;
                    r_row      <= r_row + ROW_CW'(1);
                    r_bank_sel <= next_bank(r_bank_sel);
                    // A new line opens only after all three banks got a row.
                    if (r_bank_sel == 2'd2)
                        r_line_off <= r_line_off + ADDR_W'(ROW_W);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            if (i_fc_beat)
                r_fc_cnt <= r_fc_cnt + FC_W'(1);
        end
    end

    // Sums wrap modulo 2^ADDR_W by truncation.
    assign o_conv_addr = r_base + r_line_off + ADDR_W'(r_col);
    assign o_fc_addr   = r_base + ADDR_W'(r_fc_cnt);
    assign o_bank_sel  = r_bank_sel;
    assign o_conv_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign o_fc_last   = (r_fc_cnt == FC_LAST);

endmodule

// File: rtl/act_mem_write_controller.sv
// Activation memory write controller: stores conv output rows round-robin
// across three banks and FC outputs linearly in bank 1, then flags layer_done.
module act_mem_write_controller
    import act_mem_pkg::*;
#(
    parameter int ROW_W  = AM_ROW_W,
    parameter int ROWS   = AM_ROWS,
    parameter int FC_LEN = AM_FC_LEN,
    parameter int ADDR_W = AM_ADDR_W,
    parameter int DATA_W = AM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        conv_or_fc,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out_data,
    output logic              out_ready,
    output logic [ADDR_W-1:0] act_mem_wr_addr_1,
    output logic [ADDR_W-1:0] act_mem_wr_addr_2,
    output logic [ADDR_W-1:0] act_mem_wr_addr_3,
    output logic              act_mem_we_1,
    output logic              act_mem_we_2,
    output logic              act_mem_we_3,
    output logic [DATA_W-1:0] act_mem_wr_data,
    output logic              layer_done
);

    wr_state_t r_state;
    wr_state_t w_next_state;

    logic              w_load;
    logic              w_conv_beat;
    logic              w_fc_beat;
    logic [ADDR_W-1:0] w_conv_addr;
    logic [ADDR_W-1:0] w_fc_addr;
    logic [1:0]        w_bank_sel;
    logic              w_conv_last;
    logic              w_fc_last;

    logic [ADDR_W-1:0] r_wr_addr_1;
    logic [ADDR_W-1:0] r_wr_addr_2;
    logic [ADDR_W-1:0] r_wr_addr_3;
    logic              r_we_1;
    logic              r_we_2;
    logic              r_we_3;
    logic [DATA_W-1:0] r_wr_data;

    act_wr_addr_gen #(
        .ROW_W  (ROW_W),
        .ROWS   (ROWS),
        .FC_LEN (FC_LEN),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_base_addr (base_addr),
        .i_conv_beat (w_conv_beat),
        .i_fc_beat   (w_fc_beat),
        .o_conv_addr (w_conv_addr),
        .o_bank_sel  (w_bank_sel),
        .o_conv_last (w_conv_last),
        .o_fc_addr   (w_fc_addr),
        .o_fc_last   (w_fc_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        out_ready    = 1'b0;
        layer_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && conv_or_fc == CONV) begin
                    w_next_state = ST_WR_CONV;
                    w_load       = 1'b1;
                end else if (start && conv_or_fc == FC) begin
                    w_next_state = ST_WR_FC;
                    w_load       = 1'b1;
                end
            end
            ST_WR_CONV: begin
                out_ready = 1'b1;
                if (out_valid && w_conv_last) w_next_state = ST_DONE;
            end
            ST_WR_FC: begin
                out_ready = 1'b1;
                if (out_valid && w_fc_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                layer_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_conv_beat = out_valid && (r_state == ST_WR_CONV);
    assign w_fc_beat   = out_valid && (r_state == ST_WR_FC);

    // Write port registers; an address only moves when its bank is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr_1 <= '0;
            r_wr_addr_2 <= '0;
            r_wr_addr_3 <= '0;
            r_we_1      <= 1'b0;
            r_we_2      <= 1'b0;
            r_we_3      <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            r_we_1 <= 1'b0;
            r_we_2 <= 1'b0;
            r_we_3 <= 1'b0;
            if (w_conv_beat || w_fc_beat)
                r_wr_data <= out_data;
            if (w_fc_beat) begin
                r_we_1      <= 1'b1;
                r_wr_addr_1 <= w_fc_addr;
            end else if (w_conv_beat) begin
                unique case (w_bank_sel)
                    2'd0: begin
                        r_we_1      <= 1'b1;
                        r_wr_addr_1 <= w_conv_addr;
                    end
                    2'd1: begin
                        r_we_2      <= 1'b1;
                        r_wr_addr_2 <= w_conv_addr;
                    end
                    default: begin
                        r_we_3      <= 1'b1;
                        r_wr_addr_3 <= w_conv_addr;
                    end
                endcase
            end
        end
    end

    assign act_mem_wr_addr_1 = r_wr_addr_1;
    assign act_mem_wr_addr_2 = r_wr_addr_2;
    assign act_mem_wr_addr_3 = r_wr_addr_3;
    assign act_mem_we_1      = r_we_1;
    assign act_mem_we_2      = r_we_2;
    assign act_mem_we_3      = r_we_3;
    assign act_mem_wr_data   = r_wr_data;

endmodule

// File: tb/tb_act_mem_write_controller.sv
// Self-checking bench for act_mem_write_controller: a table of layer runs is
// compared write-by-write against a row/bank/line model, plus corner sequences.
module tb_act_mem_write_controller;
    import act_mem_pkg::*;

    localparam int ADDR_W = AM_ADDR_W;
    localparam int DATA_W = AM_DATA_W;
    localparam int ROW_W  = AM_ROW_W;
    localparam int ROWS   = AM_ROWS;
    localparam int FC_LEN = AM_FC_LEN;
    localparam int AMASK  = (1 << ADDR_W) - 1;
    localparam int CONV_N = ROW_W * ROWS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        conv_or_fc;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [ADDR_W-1:0] act_mem_wr_addr_1;
    logic [ADDR_W-1:0] act_mem_wr_addr_2;
    logic [ADDR_W-1:0] act_mem_wr_addr_3;
    logic              act_mem_we_1;
    logic              act_mem_we_2;
    logic              act_mem_we_3;
    logic [DATA_W-1:0] act_mem_wr_data;
    logic              layer_done;

    act_mem_write_controller dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .conv_or_fc        (conv_or_fc),
        .base_addr         (base_addr),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .act_mem_wr_addr_1 (act_mem_wr_addr_1),
        .act_mem_wr_addr_2 (act_mem_wr_addr_2),
        .act_mem_wr_addr_3 (act_mem_wr_addr_3),
        .act_mem_we_1      (act_mem_we_1),
        .act_mem_we_2      (act_mem_we_2),
        .act_mem_we_3      (act_mem_we_3),
        .act_mem_wr_data   (act_mem_wr_data),
        .layer_done        (layer_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Write log captured from the memory ports, sampled on the falling edge.
    int log_bank[$];
    int log_addr[$];
    int log_data[$];
    int done_cnt;
    int done_at_len;
    int hot_err;

    always @(negedge clk) begin
        if ($countones({act_mem_we_3, act_mem_we_2, act_mem_we_1}) > 1) hot_err++;
        if (act_mem_we_1) begin
            log_bank.push_back(1); log_addr.push_back(int'(act_mem_wr_addr_1)); log_data.push_back(int'(act_mem_wr_data));
        end else if (act_mem_we_2) begin
            log_bank.push_back(2); log_addr.push_back(int'(act_mem_wr_addr_2)); log_data.push_back(int'(act_mem_wr_data));
        end else if (act_mem_we_3) begin
            log_bank.push_back(3); log_addr.push_back(int'(act_mem_wr_addr_3)); log_data.push_back(int'(act_mem_wr_data));
        end
        if (layer_done) begin
            done_cnt++;
            done_at_len = log_bank.size();
        end
    end

    // Reference placement: conv row r = k / ROW_W lands in bank r mod 3,
    // line r / 3; FC word k lands in bank 1 at base + k.
    int exp_bank[$];
    int exp_addr[$];
    int exp_data[$];

    function automatic int model_bank(input logic [1:0] mode, input int k);
        if (mode == FC) return 1;
        return (k / ROW_W) % 3 + 1;
    endfunction

    function automatic int model_addr(input logic [1:0] mode, input int base, input int k);
        int r;
        if (mode == FC) return (base + k) & AMASK;
        r = k / ROW_W;
        return (base + (r / 3) * ROW_W + (k % ROW_W)) & AMASK;
    endfunction

    task automatic clear_logs();
        log_bank.delete(); log_addr.delete(); log_data.delete();
        exp_bank.delete(); exp_addr.delete(); exp_data.delete();
        done_cnt    = 0;
        done_at_len = -1;
        hot_err     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_ready"},  32'(out_ready), 0);
        check({tag, " we_1"},       32'(act_mem_we_1), 0);
        check({tag, " we_2"},       32'(act_mem_we_2), 0);
        check({tag, " we_3"},       32'(act_mem_we_3), 0);
        check({tag, " addr_1"},     32'(act_mem_wr_addr_1), 0);
        check({tag, " addr_2"},     32'(act_mem_wr_addr_2), 0);
        check({tag, " addr_3"},     32'(act_mem_wr_addr_3), 0);
        check({tag, " wr_data"},    32'(act_mem_wr_data), 0);
        check({tag, " layer_done"}, 32'(layer_done), 0);
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         base;
        int         n;          // beats in the layer
        int         vpat;       // 0 continuous, 1 toggling, 2 random
        int         abort_at;   // beat index at which rst is raised, -1 none
        bit         poke;       // pulse start mid-layer
        int         exp_writes;
        int         exp_done;
    } layer_vec_t;

    typedef struct {
        int vec;
        int beat;
        int bank;
        int addr;
    } spot_t;

    // Runs one layer; on entry the bench sits at a falling edge in IDLE.
    task automatic run_layer(input layer_vec_t v);
        int  issued  = 0;
        int  cyc     = 0;
        int  budget  = v.n * 6 + 50;
        bit  toggle  = 1'b1;
        bit  aborted = 1'b0;
        bit  poked   = 1'b0;
        int  mism    = 0;
        int  lim;
        clear_logs();
        start = 1'b1; conv_or_fc = v.mode; base_addr = ADDR_W'(v.base);
        @(negedge clk);
        start = 1'b0; conv_or_fc = 2'b00; base_addr = ADDR_W'($urandom);
        while (issued < v.n && cyc < budget) begin
            if (v.abort_at >= 0 && issued == v.abort_at) begin
                rst = 1'b1; out_valid = 1'b1;
                aborted = 1'b1;
                break;
            end
            case (v.vpat)
                0:       out_valid = 1'b1;
                1:       begin out_valid = toggle; toggle = ~toggle; end
                default: out_valid = ($urandom_range(0, 3) != 0);
            endcase
            out_data = DATA_W'($urandom);
            if (v.poke && !poked && issued == 50) begin
                start = 1'b1; conv_or_fc = FC; base_addr = ADDR_W'(777);
                poked = 1'b1;
            end
            if (out_valid && out_ready) begin
                exp_bank.push_back(model_bank(v.mode, issued));
                exp_addr.push_back(model_addr(v.mode, v.base, issued));
                exp_data.push_back(int'(out_data));
                issued++;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0; conv_or_fc = 2'b00;
        end
        if (aborted) begin
            @(negedge clk);
            check_all_zero({v.name, " after rst"});
            rst = 1'b0; out_valid = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            out_valid = 1'b0;
            if (issued < v.n) check({v.name, " timeout beats"}, issued, v.n);
            else check({v.name, " out_ready after last beat"}, 32'(out_ready), 0);
            repeat (3) @(negedge clk);
            check({v.name, " done at last write"}, done_at_len, v.exp_writes);
        end
        check({v.name, " write count"}, log_bank.size(), v.exp_writes);
        lim = (log_bank.size() < exp_bank.size()) ? log_bank.size() : exp_bank.size();
        for (int k = 0; k < lim; k++)
            if (log_bank[k] != exp_bank[k] || log_addr[k] != exp_addr[k] || log_data[k] != exp_data[k])
                mism++;
        check({v.name, " write sequence mismatches"}, mism, 0);
        check({v.name, " layer_done pulses"}, done_cnt, v.exp_done);
        check({v.name, " multi-hot we"}, hot_err, 0);
    endtask

    layer_vec_t vecs[9];
    spot_t      spots[6];

    initial begin
        rst = 1'b1; start = 1'b0; conv_or_fc = 2'b00; base_addr = '0;
        out_valid = 1'b0; out_data = '0;
        clear_logs();

        vecs[0] = '{"conv_cont",   CONV, 0,    CONV_N, 0, -1,  1'b0, CONV_N, 1};
        vecs[1] = '{"conv_toggle", CONV, 0,    CONV_N, 1, -1,  1'b0, CONV_N, 1};
        vecs[2] = '{"fc_base100",  FC,   100,  FC_LEN, 0, -1,  1'b0, FC_LEN, 1};
        vecs[3] = '{"conv_poke",   CONV, 300,  CONV_N, 0, -1,  1'b1, CONV_N, 1};
        vecs[4] = '{"conv_wrap",   CONV, 8180, CONV_N, 0, -1,  1'b0, CONV_N, 1};
        vecs[5] = '{"conv_abort",  CONV, 0,    CONV_N, 0, 100, 1'b0, 100,    0};
        vecs[6] = '{"conv_fresh",  CONV, 48,   CONV_N, 2, -1,  1'b0, CONV_N, 1};
        vecs[7] = '{"fc_rand",     FC,   int'($urandom_range(0, AMASK)), FC_LEN, 2, -1, 1'b0, FC_LEN, 1};
        vecs[8] = '{"conv_rand",   CONV, int'($urandom_range(0, AMASK)), CONV_N, 2, -1, 1'b0, CONV_N, 1};

        spots[0] = '{0, 0,   1, 0};
        spots[1] = '{0, 16,  2, 0};
        spots[2] = '{0, 32,  3, 0};
        spots[3] = '{0, 48,  1, 16};
        spots[4] = '{0, 223, 2, 79};
        spots[5] = '{4, 12,  1, 0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Starts with an invalid mode must be ignored even with data waiting.
        clear_logs();
        out_valid = 1'b1;
        start = 1'b1; conv_or_fc = 2'b11; base_addr = ADDR_W'(5);
        @(negedge clk);
        conv_or_fc = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("bad mode out_ready", 32'(out_ready), 0);
        check("bad mode writes", log_bank.size(), 0);
        check("bad mode done", done_cnt, 0);
        out_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_layer(vecs[i]);
            for (int s = 0; s < 6; s++) begin
                if (spots[s].vec == i) begin
                    if (log_bank.size() > spots[s].beat) begin
                        check($sformatf("%s beat %0d bank", vecs[i].name, spots[s].beat), log_bank[spots[s].beat], spots[s].bank);
                        check($sformatf("%s beat %0d addr", vecs[i].name, spots[s].beat), log_addr[spots[s].beat], spots[s].addr);
                    end else begin
                        check($sformatf("%s beat %0d present", vecs[i].name, spots[s].beat), log_bank.size(), spots[s].beat + 1);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
